// File: rtl/residual_modulo_map_pkg.sv
// ----------------------------------------------------------------------------
// residual_modulo_map_pkg
// Shared constants for the residual modulo-reduction / error-mapping stage:
// default widths, the reduction RANGE and the coding-mode codes carried with
// every residual word.
// ----------------------------------------------------------------------------
package residual_modulo_map_pkg;

  localparam int PIXEL_LENGTH    = 8;
  localparam int RESIDUAL_LENGTH = PIXEL_LENGTH + 1;
  localparam int MODE_LENGTH     = 2;
  localparam int RANGE           = 1 << PIXEL_LENGTH;

  typedef enum logic [MODE_LENGTH-1:0] {
    MODE_REG     = 2'd0,  // regular mode, MErrval
    MODE_RUN     = 2'd1,  // run mode, nothing to map
    MODE_RI      = 2'd2,  // run interruption, EMErrval
    MODE_ILLEGAL = 2'd3
  } mode_e;

endpackage : residual_modulo_map_pkg

// File: rtl/residual_modulo_map_err_map_comb.sv
// ----------------------------------------------------------------------------
// residual_modulo_map_err_map_comb
// Purely combinational second-stage mapping of a reduced Errval to the
// non-negative value consumed by the Golomb coder.
//   e          in   pixel_length     reduced Errval, two's complement
//   mode       in   mode_length      coding mode of the word
//   ri_type    in   1                run-interruption type (mode RI only)
//   ri_map     in   1                run-interruption map bit (mode RI only)
//   k_zero_map in   1                regular-mode special map (mode REG only)
//   merr       out  residual_length  MErrval (REG) / EMErrval (RI)
// ----------------------------------------------------------------------------
module residual_modulo_map_err_map_comb
  import residual_modulo_map_pkg::*;
#(
  parameter int pixel_length    = PIXEL_LENGTH,
  parameter int residual_length = RESIDUAL_LENGTH,
  parameter int mode_length     = MODE_LENGTH
) (
  input  logic [pixel_length-1:0]    e,
  input  logic [mode_length-1:0]     mode,
  input  logic                       ri_type,
  input  logic                       ri_map,
  input  logic                       k_zero_map,
  output logic [residual_length-1:0] merr
);

  // One bit of headroom over the output so 2|e| = 2*128 = 256 is representable
  // before the final subtractions.
  localparam int W = residual_length + 1;
  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] TWO = W'(2);

  logic         neg;
  logic [W-1:0] e2;    // 2e, two's complement
  logic [W-1:0] mag2;  // 2|e|
  logic [W-1:0] acc;
  logic         unused_acc_msb;

  assign neg  = e[pixel_length-1];
  assign e2   = {{(W-pixel_length-1){e[pixel_length-1]}}, e, 1'b0};
  assign mag2 = neg ? -e2 : e2;

  // NOTE: every output of an always_comb is given a value before any branch,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    acc = '0;
    if (mode == mode_length'(MODE_REG)) begin
      if (k_zero_map) acc = neg ? (mag2 - TWO) : (e2 + ONE);
      else            acc = neg ? (mag2 - ONE) : e2;
    end else if (mode == mode_length'(MODE_RI)) begin
      acc = mag2 - {{(W-1){1'b0}}, ri_type} - {{(W-1){1'b0}}, ri_map};
    end
  end

  assign merr           = acc[residual_length-1:0];
  // Legal inputs never set the headroom bit.
  assign unused_acc_msb = acc[residual_length];

endmodule : residual_modulo_map_err_map_comb

// File: rtl/residual_modulo_map.sv
// ----------------------------------------------------------------------------
// residual_modulo_map
// Two-stage valid/ready pipeline after prediction-residual computation.
// S1 reduces the signed residual modulo RANGE into [-RANGE/2, RANGE/2-1];
// S2 maps it to MErrval (regular) or EMErrval (run interruption).
// Run-mode and illegal-mode words are accepted but never reach S2.
//   clk          in   1                clock, rising edge
//   reset_n      in   1                asynchronous active-low reset
//   flush        in   1                synchronous pipeline clear
//   in_valid     in   1                upstream residual valid
//   in_ready     out  1                stage can accept this cycle
//   x_residual   in   residual_length  two's-complement residual
//   mode         in   mode_length      coding mode
//   RIType       in   1                run-interruption type
//   ri_map       in   1                run-interruption map bit
//   k_zero_map   in   1                regular-mode special map
//   out_valid    out  1                mapped value valid
//   out_ready    in   1                Golomb coder accepts
//   merr         out  residual_length  MErrval / EMErrval
//   err_mod      out  pixel_length     reduced Errval for context update
//   out_mode     out  mode_length      mode travelling with the data
//   illegal_mode out  1                sticky: a mode-3 word was accepted
// ----------------------------------------------------------------------------
module residual_modulo_map
  import residual_modulo_map_pkg::*;
#(
  parameter int pixel_length    = PIXEL_LENGTH,
  parameter int residual_length = RESIDUAL_LENGTH,
  parameter int mode_length     = MODE_LENGTH
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [residual_length-1:0]     x_residual,
  input  logic [mode_length-1:0]         mode,
  input  logic                           RIType,
  input  logic                           ri_map,
  input  logic                           k_zero_map,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [residual_length-1:0]     merr,
  output logic signed [pixel_length-1:0] err_mod,
  output logic [mode_length-1:0]         out_mode,
  output logic                           illegal_mode
);

  localparam int RANGE_L = 1 << pixel_length;
  localparam logic signed [residual_length-1:0] HALF_POS = residual_length'(RANGE_L / 2);
  localparam logic signed [residual_length-1:0] HALF_NEG = -HALF_POS;
  localparam logic signed [residual_length-1:0] RANGE_W  = residual_length'(RANGE_L);

  // Stage 1 state
  logic                       s1_valid;
  logic [pixel_length-1:0]    s1_err;
  logic [mode_length-1:0]     s1_mode;
  logic                       s1_ri_type;
  logic                       s1_ri_map;
  logic                       s1_k_zero_map;

  // Stage 2 state (drives the outputs directly)
  logic                       s2_valid;
  logic [residual_length-1:0] s2_merr;
  logic [pixel_length-1:0]    s2_err;
  logic [mode_length-1:0]     s2_mode;
  logic                       illegal_q;

  logic                       s1_adv;
  logic                       s1_open;
  logic                       accept;
  logic                       keep_word;
  logic signed [residual_length-1:0] x_s;
  logic signed [residual_length-1:0] reduced;
  logic [residual_length-1:0] merr_d;
  logic                       unused_reduced_msbs;

  // S2 can take a new word when empty or when its word leaves this cycle;
  // S1 can take one when empty or when its word moves on. Both may happen in
  // the same cycle, so a continuous stream flows without bubbles.
  assign s1_adv    = ~s2_valid | out_ready;
  assign s1_open   = ~s1_valid | s1_adv;
  assign in_ready  = ~flush & s1_open;
  assign accept    = in_valid & in_ready;
  assign keep_word = (mode == mode_length'(MODE_REG)) | (mode == mode_length'(MODE_RI));

  // Modulo-RANGE reduction. After the correction the value lies in
  // [-RANGE/2, RANGE/2-1], so its low pixel_length bits carry it exactly.
  assign x_s = $signed(x_residual);
  always_comb begin
    reduced = x_s;
    if (x_s < HALF_NEG)       reduced = x_s + RANGE_W;
    else if (x_s >= HALF_POS) reduced = x_s - RANGE_W;
  end
  assign unused_reduced_msbs = ^reduced[residual_length-1:pixel_length];

  residual_modulo_map_err_map_comb #(
    .pixel_length   (pixel_length),
    .residual_length(residual_length),
    .mode_length    (mode_length)
  ) u_err_map_comb (
    .e         (s1_err),
    .mode      (s1_mode),
    .ri_type   (s1_ri_type),
    .ri_map    (s1_ri_map),
    .k_zero_map(s1_k_zero_map),
    .merr      (merr_d)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: datapath registers are reset too, because the outputs they drive
  // must read 0 out of reset, not only be qualified by out_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid      <= 1'b0;
      s1_err        <= '0;
      s1_mode       <= '0;
      s1_ri_type    <= 1'b0;
      s1_ri_map     <= 1'b0;
      s1_k_zero_map <= 1'b0;
      s2_valid      <= 1'b0;
      s2_merr       <= '0;
      s2_err        <= '0;
      s2_mode       <= '0;
      illegal_q     <= 1'b0;
    end else begin
      // Stage 1: run / illegal words are consumed here and never marked valid.
      if (flush)        s1_valid <= 1'b0;
      else if (s1_open) s1_valid <= accept & keep_word;

      if (accept) begin
        s1_err        <= reduced[pixel_length-1:0];
        s1_mode       <= mode;
        s1_ri_type    <= RIType;
        s1_ri_map     <= ri_map;
        s1_k_zero_map <= k_zero_map;
        if (mode == mode_length'(MODE_ILLEGAL)) illegal_q <= 1'b1;
      end

      // Stage 2: data only changes when a word moves in, so it holds while
      // the coder stalls.
      if (flush)       s2_valid <= 1'b0;
      else if (s1_adv) s2_valid <= s1_valid;

      if (!flush && s1_valid && s1_adv) begin
        s2_merr <= merr_d;
        s2_err  <= s1_err;
        s2_mode <= s1_mode;
      end
    end
  end

  assign out_valid    = s2_valid;
  assign merr         = s2_merr;
  assign err_mod      = $signed(s2_err);
  assign out_mode     = s2_mode;
  assign illegal_mode = illegal_q;

endmodule : residual_modulo_map

// File: tb/tb_residual_modulo_map.sv
// ----------------------------------------------------------------------------
// tb_residual_modulo_map
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences (stall, mode drop, illegal flag, flush, reset) and a randomized
// stream checked against an arithmetic reference model and scoreboard queue.
// ----------------------------------------------------------------------------
module tb_residual_modulo_map;

  localparam int PL = 8;
  localparam int RL = 9;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [RL-1:0] x_residual;
  logic [ML-1:0] mode;
  logic          RIType;
  logic          ri_map;
  logic          k_zero_map;
  logic          out_valid;
  logic          out_ready;
  logic [RL-1:0] merr;
  logic [PL-1:0] err_mod;
  logic [ML-1:0] out_mode;
  logic          illegal_mode;

  residual_modulo_map #(
    .pixel_length(PL), .residual_length(RL), .mode_length(ML)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_residual(x_residual), .mode(mode), .RIType(RIType),
    .ri_map(ri_map), .k_zero_map(k_zero_map),
    .out_valid(out_valid), .out_ready(out_ready),
    .merr(merr), .err_mod(err_mod), .out_mode(out_mode),
    .illegal_mode(illegal_mode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [31:0] actual,
                       input logic signed [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int ref_err(input int x);
    int e;
    e = x;
    if (e < -128)      e = e + 256;
    else if (e >= 128) e = e - 256;
    return e;
  endfunction

  function automatic int ref_merr(input int m, input int e, input int rit,
                                  input int rim, input int kzm);
    int a;
    a = (e < 0) ? -e : e;
    if (m == 2) return 2 * a - rit - rim;
    if (kzm != 0) return (e >= 0) ? 2 * e + 1 : -2 * e - 2;
    return (e >= 0) ? 2 * e : -2 * e - 1;
  endfunction

  // ---------------- scoreboard monitor (negedge sampling) ----------------
  typedef struct { int err; int merr; int m; } exp_t;
  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  int   n_out  = 0;
  bit   held   = 1'b0;
  int   held_merr;

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      exp_t ex;
      int   xin;
      if (held) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_merr", merr, held_merr);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          ex = exp_q.pop_front();
          check("stream_merr", merr, ex.merr);
          check("stream_err_mod", $signed(err_mod), ex.err);
          check("stream_out_mode", out_mode, ex.m);
        end
      end
      held      = out_valid && !out_ready;
      held_merr = merr;
      if (in_valid && in_ready && (mode == 2'd0 || mode == 2'd2)) begin
        xin     = $signed(x_residual);
        ex.m    = mode;
        ex.err  = ref_err(xin);
        ex.merr = ref_merr(ex.m, ex.err, RIType, ri_map, k_zero_map);
        exp_q.push_back(ex);
      end
    end else begin
      held = 1'b0;
    end
  end

  // ---------------- driver helpers (all start/end at posedge+#1) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int x, input int m, input int rit, input int rim, input int kzm);
    x_residual = RL'(x);
    mode       = ML'(m);
    RIType     = rit[0];
    ri_map     = rim[0];
    k_zero_map = kzm[0];
  endtask

  task automatic send(input int x, input int m, input int rit, input int rim, input int kzm);
    bit acc;
    acc = 1'b0;
    set_word(x, m, rit, rim, kzm);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      #1 acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 100 && (exp_q.size() != 0 || out_valid); i++) tick();
    check("drain_done", (exp_q.size() == 0 && !out_valid), 1);
  endtask

  task automatic gen_word(input bit allow_run, output int x, output int m,
                          output int rit, output int rim, output int kzm);
    int r;
    x   = $signed(RL'($urandom_range(0, 511)));
    r   = $urandom_range(0, 3);
    m   = (r == 3 && allow_run) ? 1 : ((r == 2) ? 2 : 0);
    rit = $urandom_range(0, 1);
    rim = $urandom_range(0, 1);
    kzm = $urandom_range(0, 1);
    if (m == 2 && ref_err(x) == 0) begin
      rit = 0;
      rim = 0;
    end
  endtask

  // Stream driver: window=1 stalls out_ready on cycles 3..5 with in_valid
  // held high; window=0 randomizes both handshake sides.
  task automatic run_stream(input int nwords, input bit window);
    int  idx, c, x, m, rit, rim, kzm;
    bit  acc;
    idx = 0;
    c   = 0;
    gen_word(!window, x, m, rit, rim, kzm);
    while (idx < nwords && c < 5000) begin
      out_ready = window ? !(c >= 3 && c <= 5) : ($urandom_range(0, 3) != 0);
      set_word(x, m, rit, rim, kzm);
      in_valid = window ? 1'b1 : ($urandom_range(0, 4) != 0);
      #1 acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      c++;
      if (acc) begin
        idx++;
        gen_word(!window, x, m, rit, rim, kzm);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_words_sent", idx, nwords);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_merr", merr, 0);
    check("reset_err_mod", $signed(err_mod), 0);
    check("reset_out_mode", out_mode, 0);
    check("reset_illegal", illegal_mode, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("reset_in_ready", in_ready, 1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int x; int m; int rit; int rim; int kzm; int exp_err; int exp_merr;
  } vec_t;
  vec_t vecs[14];

  initial begin
    int waited, base;

    vecs[0]  = '{-16,  0, 0, 0, 0,  -16,  31};
    vecs[1]  = '{200,  0, 0, 0, 0,  -56, 111};
    vecs[2]  = '{-200, 0, 0, 0, 0,   56, 112};
    vecs[3]  = '{128,  0, 0, 0, 0, -128, 255};
    vecs[4]  = '{-128, 2, 0, 0, 0, -128, 256};
    vecs[5]  = '{-128, 2, 1, 1, 0, -128, 254};
    vecs[6]  = '{5,    0, 0, 0, 1,    5,  11};
    vecs[7]  = '{-3,   0, 0, 0, 1,   -3,   4};
    vecs[8]  = '{255,  0, 0, 0, 0,   -1,   1};
    vecs[9]  = '{-256, 0, 0, 0, 0,    0,   0};
    vecs[10] = '{-129, 0, 0, 0, 0,  127, 254};
    vecs[11] = '{3,    2, 1, 0, 0,    3,   5};
    vecs[12] = '{127,  2, 0, 1, 0,  127, 253};
    vecs[13] = '{-1,   0, 0, 0, 1,   -1,   0};

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_word(0, 0, 0, 0, 0);
    #2;
    do_reset();

    // Directed vectors: one word at a time, latency must be exactly 2 cycles
    // (out_valid one edge after the accepting edge).
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].x, vecs[i].m, vecs[i].rit, vecs[i].rim, vecs[i].kzm);
      waited = 0;
      while (!out_valid && waited < 6) begin
        tick();
        waited++;
      end
      check($sformatf("vec%0d_latency", i), waited, 1);
      check($sformatf("vec%0d_err_mod", i), $signed(err_mod), vecs[i].exp_err);
      check($sformatf("vec%0d_merr", i), merr, vecs[i].exp_merr);
      check($sformatf("vec%0d_out_mode", i), out_mode, vecs[i].m);
      tick();
      check($sformatf("vec%0d_drained", i), out_valid, 0);
    end

    // Eight back-to-back words with the coder stalled on cycles 3..5.
    mon_en = 1'b1;
    base   = n_out;
    run_stream(8, 1'b1);
    drain();
    check("stall_output_count", n_out - base, 8);

    // Run-mode word between two regular words yields exactly two outputs.
    base = n_out;
    send(10, 0, 0, 0, 0);
    send(20, 1, 0, 0, 0);
    send(-30, 0, 0, 0, 1);
    drain();
    check("run_drop_count", n_out - base, 2);

    // Illegal mode: sticky flag, no output.
    check("illegal_before", illegal_mode, 0);
    base = n_out;
    send(7, 3, 0, 0, 0);
    drain();
    check("illegal_set", illegal_mode, 1);
    check("illegal_no_output", n_out - base, 0);

    // Randomized traffic against the model; the flag must survive it.
    base = n_out;
    run_stream(300, 1'b0);
    drain();
    check("illegal_sticky", illegal_mode, 1);
    mon_en = 1'b0;

    // Flush with both stages full and a word offered.
    exp_q.delete();
    out_ready = 1'b0;
    send(40, 0, 0, 0, 0);
    send(50, 0, 0, 0, 0);
    check("flush_pre_full_valid", out_valid, 1);
    check("flush_pre_full_ready", in_ready, 0);
    set_word(60, 0, 0, 0, 0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("flush_empty_%0d", i), out_valid, 0);
    end
    check("flush_ready_after", in_ready, 1);

    // Reset mid-operation: in-flight words vanish, sticky flag clears.
    out_ready = 1'b0;
    send(70, 0, 0, 0, 0);
    send(80, 2, 0, 0, 0);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_reset_empty_%0d", i), out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_residual_modulo_map
